// File: rtl/inst_queue_pkg.sv
// -----------------------------------------------------------------------------
// inst_queue_pkg
// Purpose : Shared constants and types for the IF->ID instruction queue.
//           Holds the queue geometry, the {pc, inst} entry type, the fetch and
//           issue slot widths, the pipeline-controller constants, and a
//           saturating adder used by the optional statistics counters.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package inst_queue_pkg;

  // Pipeline-controller constants, shared across the front end.
  localparam logic RstEnable = 1'b1;
  localparam logic Flush     = 1'b1;
  localparam logic Stop      = 1'b1;

  // Queue geometry.
  localparam int IQ_DEPTH  = 16;
  localparam int IQ_PTR_W  = 4;
  localparam int IQ_ADDR_W = 32;
  localparam int IQ_DATA_W = 32;

  // Slot counts on each side of the queue and the width of their count fields.
  localparam int IQ_FETCH_SLOTS = 2;
  localparam int IQ_ISSUE_SLOTS = 2;
  localparam int IQ_FETCH_W     = 2;
  localparam int IQ_ISSUE_W     = 2;

  typedef struct packed {
    logic [IQ_ADDR_W-1:0] pc;
    logic [IQ_DATA_W-1:0] inst;
  } iq_entry_t;

  // 32-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a,
                                            input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/inst_queue_if.sv
// -----------------------------------------------------------------------------
// inst_queue_if
// Purpose : Bundles the controller, fetch-side and decode-side signals of the
//           instruction queue.
// Signals : flush_i, stall_i[3:0]           controller -> queue
//           fetch_num_i, fetch_pc0/1_i,
//           fetch_inst0/1_i                 fetch -> queue
//           full_o                          queue -> fetch (back-pressure)
//           issue_valid_o, issue_pc0/1_o,
//           issue_inst0/1_o                 queue -> decode
//           issue_num_i                     decode -> queue
// Modports: master = pipeline side (drives *_i), slave = the queue.
// -----------------------------------------------------------------------------
interface inst_queue_if
  import inst_queue_pkg::*;
#(
  parameter int ADDR_W = IQ_ADDR_W,
  parameter int DATA_W = IQ_DATA_W
) ();

  logic                  flush_i;
  logic [3:0]            stall_i;
  logic [IQ_FETCH_W-1:0] fetch_num_i;
  logic [ADDR_W-1:0]     fetch_pc0_i;
  logic [ADDR_W-1:0]     fetch_pc1_i;
  logic [DATA_W-1:0]     fetch_inst0_i;
  logic [DATA_W-1:0]     fetch_inst1_i;
  logic                  full_o;
  logic [1:0]            issue_valid_o;
  logic [ADDR_W-1:0]     issue_pc0_o;
  logic [ADDR_W-1:0]     issue_pc1_o;
  logic [DATA_W-1:0]     issue_inst0_o;
  logic [DATA_W-1:0]     issue_inst1_o;
  logic [IQ_ISSUE_W-1:0] issue_num_i;

  modport master (
    output flush_i, stall_i, fetch_num_i, fetch_pc0_i, fetch_pc1_i,
           fetch_inst0_i, fetch_inst1_i, issue_num_i,
    input  full_o, issue_valid_o, issue_pc0_o, issue_pc1_o,
           issue_inst0_o, issue_inst1_o
  );

  modport slave (
    input  flush_i, stall_i, fetch_num_i, fetch_pc0_i, fetch_pc1_i,
           fetch_inst0_i, fetch_inst1_i, issue_num_i,
    output full_o, issue_valid_o, issue_pc0_o, issue_pc1_o,
           issue_inst0_o, issue_inst1_o
  );

endinterface

// File: rtl/inst_queue_iq_regfile.sv
// -----------------------------------------------------------------------------
// iq_regfile
// Purpose : Entry storage for inst_queue. DEPTH x WIDTH array with two write
//           ports and two combinational read ports; no reset on contents.
// Ports   : clk                     clock
//           i_we0/i_waddr0/i_wdata0  write port 0
//           i_we1/i_waddr1/i_wdata1  write port 1 (never the same index as
//                                   port 0 in one cycle)
//           i_raddr0 -> o_rdata0     read port 0
//           i_raddr1 -> o_rdata1     read port 1
// -----------------------------------------------------------------------------
module iq_regfile #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             i_we0,
  input  logic [PTR_W-1:0] i_waddr0,
  input  logic [WIDTH-1:0] i_wdata0,
  input  logic             i_we1,
  input  logic [PTR_W-1:0] i_waddr1,
  input  logic [WIDTH-1:0] i_wdata1,
  input  logic [PTR_W-1:0] i_raddr0,
  output logic [WIDTH-1:0] o_rdata0,
  input  logic [PTR_W-1:0] i_raddr1,
  output logic [WIDTH-1:0] o_rdata1
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we0) r_mem[i_waddr0] <= i_wdata0;
    if (i_we1) r_mem[i_waddr1] <= i_wdata1;
  end

  // Decode must see the head entries in the same cycle, so reads are not
  // registered; this maps to distributed RAM or flops.
  assign o_rdata0 = r_mem[i_raddr0];
  assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
// Purpose : Instruction buffer between fetch and decode. Takes up to two
//           {pc, inst} pairs per cycle, presents the two oldest entries to
//           decode, holds while decode is stalled, empties on flush and
//           raises full_o when fewer than two entries are free.
// Ports   : clk                clock, rising edge
//           rst                synchronous, active-high reset
//           bus (slave)        controller / fetch / decode signals
//           stat_full_cycles_o cycles with full_o=1          (stats build)
//           stat_flushes_o     cycles with flush_i=1         (stats build)
//           stat_dropped_o     fetch slots dropped while full (stats build)
// Config  : `define INST_QUEUE_STATS_EN adds the three saturating counters.
// -----------------------------------------------------------------------------
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH,
  parameter int PTR_W  = IQ_PTR_W,
  parameter int ADDR_W = IQ_ADDR_W,
  parameter int DATA_W = IQ_DATA_W
) (
  input  logic        clk,
  input  logic        rst,
  inst_queue_if.slave bus
`ifdef INST_QUEUE_STATS_EN
  ,
  output logic [31:0] stat_full_cycles_o,
  output logic [31:0] stat_flushes_o,
  output logic [31:0] stat_dropped_o
`endif
);

  localparam int WIDTH = ADDR_W + DATA_W;
  // full when DEPTH - count < 2, i.e. count > DEPTH - 2
  localparam logic [PTR_W:0] FULL_THR = (PTR_W+1)'(DEPTH - 2);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic             w_full;
  logic             w_clear;
  logic [1:0]       w_enq;
  logic [1:0]       w_deq;
  logic [1:0]       w_req;
  logic             w_unused_stall;
  logic [WIDTH-1:0] w_rdata0;
  logic [WIDTH-1:0] w_rdata1;

  assign w_full         = (r_count > FULL_THR);
  assign w_clear        = (rst == RstEnable) || (bus.flush_i == Flush);
  // Only the decode-hold bit matters here; fetch is held via full_o.
  assign w_unused_stall = ^bus.stall_i[3:1];

  always_comb begin
    w_enq = 2'd0;
    if (!w_full) begin
      case (bus.fetch_num_i)
        2'd0:    w_enq = 2'd0;
        2'd1:    w_enq = 2'd1;
        default: w_enq = 2'd2;   // 3 behaves as 2
      endcase
    end
  end

  always_comb begin
    w_req = (bus.issue_num_i == 2'd3) ? 2'd2 : bus.issue_num_i;   // two read ports
    w_deq = 2'd0;
    if (bus.stall_i[0] != Stop) begin
      // count < request only when count <= 1, so its low bits are the amount
      w_deq = ((PTR_W+1)'(w_req) > r_count) ? r_count[1:0] : w_req;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_deq);
      r_tail  <= r_tail + PTR_W'(w_enq);
      r_count <= r_count + (PTR_W+1)'(w_enq) - (PTR_W+1)'(w_deq);
    end
  end

  iq_regfile #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (WIDTH)
  ) u_regfile (
    .clk      (clk),
    .i_we0    (!w_clear && (w_enq != 2'd0)),
    .i_waddr0 (r_tail),
    .i_wdata0 ({bus.fetch_pc0_i, bus.fetch_inst0_i}),
    .i_we1    (!w_clear && (w_enq == 2'd2)),
    .i_waddr1 (r_tail + PTR_W'(1)),
    .i_wdata1 ({bus.fetch_pc1_i, bus.fetch_inst1_i}),
    .i_raddr0 (r_head),
    .o_rdata0 (w_rdata0),
    .i_raddr1 (r_head + PTR_W'(1)),
    .o_rdata1 (w_rdata1)
  );

  // Empty slots read as zero so stale array contents never reach decode.
  assign bus.full_o        = w_full;
  assign bus.issue_valid_o = {(r_count >= (PTR_W+1)'(2)), (r_count != '0)};
  assign bus.issue_pc0_o   = bus.issue_valid_o[0] ? w_rdata0[WIDTH-1:DATA_W] : '0;
  assign bus.issue_inst0_o = bus.issue_valid_o[0] ? w_rdata0[DATA_W-1:0]     : '0;
  assign bus.issue_pc1_o   = bus.issue_valid_o[1] ? w_rdata1[WIDTH-1:DATA_W] : '0;
  assign bus.issue_inst1_o = bus.issue_valid_o[1] ? w_rdata1[DATA_W-1:0]     : '0;

`ifdef INST_QUEUE_STATS_EN
  logic [31:0] r_stat_full;
  logic [31:0] r_stat_flush;
  logic [31:0] r_stat_drop;

  // Cleared by reset only; flush must not erase the history.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_stat_full  <= '0;
      r_stat_flush <= '0;
      r_stat_drop  <= '0;
    end else begin
      if (w_full)
        r_stat_full <= sat_add32(r_stat_full, 32'd1);
      if (bus.flush_i == Flush)
        r_stat_flush <= sat_add32(r_stat_flush, 32'd1);
      if (w_full && (bus.fetch_num_i != 2'd0))
        r_stat_drop <= sat_add32(r_stat_drop, 32'(bus.fetch_num_i));
    end
  end

  assign stat_full_cycles_o = r_stat_full;
  assign stat_flushes_o     = r_stat_flush;
  assign stat_dropped_o     = r_stat_drop;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: reset, stall hold, full/drop, wrap-around,
// flush priority and simultaneous enqueue/dequeue.
module tb_inst_queue;
  import inst_queue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  inst_queue_if iq_bus ();

`ifdef INST_QUEUE_STATS_EN
  logic [31:0] stat_full_cycles;
  logic [31:0] stat_flushes;
  logic [31:0] stat_dropped;
`endif

  inst_queue dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (iq_bus.slave)
`ifdef INST_QUEUE_STATS_EN
    ,
    .stat_full_cycles_o (stat_full_cycles),
    .stat_flushes_o     (stat_flushes),
    .stat_dropped_o     (stat_dropped)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int n, input logic [31:0] pc0, input logic [31:0] pc1);
    iq_bus.fetch_num_i   = 2'(n);
    iq_bus.fetch_pc0_i   = pc0;
    iq_bus.fetch_pc1_i   = pc1;
    iq_bus.fetch_inst0_i = inst_of(pc0);
    iq_bus.fetch_inst1_i = inst_of(pc1);
    step();
    iq_bus.fetch_num_i = 2'd0;
  endtask

  task automatic pop(input int n);
    iq_bus.issue_num_i = 2'(n);
    step();
    iq_bus.issue_num_i = 2'd0;
  endtask

  initial begin
    iq_bus.flush_i       = 1'b0;
    iq_bus.stall_i       = 4'b0000;
    iq_bus.fetch_num_i   = 2'd0;
    iq_bus.fetch_pc0_i   = '0;
    iq_bus.fetch_pc1_i   = '0;
    iq_bus.fetch_inst0_i = '0;
    iq_bus.fetch_inst1_i = '0;
    iq_bus.issue_num_i   = 2'd0;

    // ---- reset / empty ----
    rst = 1'b1;
    step();
    chk("rst_valid_c1", 64'(iq_bus.issue_valid_o), 64'(2'b00));
    step();
    chk("rst_valid_c2", 64'(iq_bus.issue_valid_o), 64'(2'b00));
    chk("rst_full", 64'(iq_bus.full_o), 64'(1'b0));
    chk("rst_pc0", 64'(iq_bus.issue_pc0_o), 64'(0));
`ifdef INST_QUEUE_STATS_EN
    chk("rst_stat_full", 64'(stat_full_cycles), 64'(0));
`endif
    rst = 1'b0;
    push(2, 32'hBFC0_0000, 32'hBFC0_0004);
    chk("first_valid", 64'(iq_bus.issue_valid_o), 64'(2'b11));
    chk("first_pc0", 64'(iq_bus.issue_pc0_o), 64'h0000_0000_BFC0_0000);
    chk("first_pc1", 64'(iq_bus.issue_pc1_o), 64'h0000_0000_BFC0_0004);
    chk("first_inst0", 64'(iq_bus.issue_inst0_o), 64'(inst_of(32'hBFC0_0000)));
    chk("first_inst1", 64'(iq_bus.issue_inst1_o), 64'(inst_of(32'hBFC0_0004)));

    // ---- stall hold: 3 entries, stalled decode asking for 2 ----
    push(1, 32'hBFC0_0008, 32'h0);
    iq_bus.stall_i     = 4'b0001;
    iq_bus.issue_num_i = 2'd2;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("stall_valid_%0d", c), 64'(iq_bus.issue_valid_o), 64'(2'b11));
      chk($sformatf("stall_pc0_%0d", c), 64'(iq_bus.issue_pc0_o), 64'h0000_0000_BFC0_0000);
    end
    iq_bus.stall_i = 4'b0000;
    step();
    iq_bus.issue_num_i = 2'd0;
    chk("unstall_valid", 64'(iq_bus.issue_valid_o), 64'(2'b01));
    chk("unstall_pc0", 64'(iq_bus.issue_pc0_o), 64'h0000_0000_BFC0_0008);
    chk("unstall_pc1_zero", 64'(iq_bus.issue_pc1_o), 64'(0));
    pop(1);
    chk("unstall_empty", 64'(iq_bus.issue_valid_o), 64'(2'b00));

    // ---- full back-pressure ----
    for (int k = 0; k < 8; k++) begin
      push(2, 32'h1000 + 32'(8 * k), 32'h1004 + 32'(8 * k));
      if (k == 6) chk("fill14_full", 64'(iq_bus.full_o), 64'(1'b0));
    end
    chk("fill16_full", 64'(iq_bus.full_o), 64'(1'b1));
    push(2, 32'hDEAD_0000, 32'hDEAD_0004);  // dropped
    chk("drop_full", 64'(iq_bus.full_o), 64'(1'b1));
    chk("drop_pc0", 64'(iq_bus.issue_pc0_o), 64'h1000);
    pop(1);
    chk("c15_full", 64'(iq_bus.full_o), 64'(1'b1));
    chk("c15_pc0", 64'(iq_bus.issue_pc0_o), 64'h1004);
    pop(1);
    chk("c14_full", 64'(iq_bus.full_o), 64'(1'b0));
    for (int j = 0; j < 7; j++) begin
      chk($sformatf("drain_pc0_%0d", j), 64'(iq_bus.issue_pc0_o), 64'(32'h1008 + 32'(8 * j)));
      chk($sformatf("drain_pc1_%0d", j), 64'(iq_bus.issue_pc1_o), 64'(32'h100C + 32'(8 * j)));
      pop(2);
    end
    chk("drain_empty", 64'(iq_bus.issue_valid_o), 64'(2'b00));
`ifdef INST_QUEUE_STATS_EN
    chk("stat_full_cycles", 64'(stat_full_cycles), 64'(3));
    chk("stat_dropped", 64'(stat_dropped), 64'(2));
`endif

    // ---- wrap-around: flush to index 0, fill 14, drain 13, push 6 ----
    iq_bus.flush_i = 1'b1;
    step();
    iq_bus.flush_i = 1'b0;
    for (int k = 0; k < 7; k++) push(2, 32'h2000 + 32'(8 * k), 32'h2004 + 32'(8 * k));
    for (int k = 0; k < 6; k++) pop(2);
    pop(1);
    chk("wrap_head13_valid", 64'(iq_bus.issue_valid_o), 64'(2'b01));
    chk("wrap_head13_pc0", 64'(iq_bus.issue_pc0_o), 64'h2034);
    push(1, 32'h3000, 32'h0);           // index 14
    push(2, 32'h3004, 32'h3008);        // indices 15, 0
    push(2, 32'h300C, 32'h3010);        // indices 1, 2
    push(1, 32'h3014, 32'h0);           // index 3
    chk("wrap_r0_pc0", 64'(iq_bus.issue_pc0_o), 64'h2034);
    chk("wrap_r0_pc1", 64'(iq_bus.issue_pc1_o), 64'h3000);
    pop(2);
    chk("wrap_r1_pc0", 64'(iq_bus.issue_pc0_o), 64'h3004);
    chk("wrap_r1_pc1", 64'(iq_bus.issue_pc1_o), 64'h3008);
    chk("wrap_r1_inst1", 64'(iq_bus.issue_inst1_o), 64'(inst_of(32'h3008)));
    pop(2);
    chk("wrap_r2_pc0", 64'(iq_bus.issue_pc0_o), 64'h300C);
    chk("wrap_r2_pc1", 64'(iq_bus.issue_pc1_o), 64'h3010);
    pop(2);
    chk("wrap_r3_valid", 64'(iq_bus.issue_valid_o), 64'(2'b01));
    chk("wrap_r3_pc0", 64'(iq_bus.issue_pc0_o), 64'h3014);
    pop(1);

    // ---- flush priority over stall and fetch ----
    push(2, 32'h4000, 32'h4004);
    push(2, 32'h4008, 32'h400C);
    push(1, 32'h4010, 32'h0);
    chk("pre_flush_valid", 64'(iq_bus.issue_valid_o), 64'(2'b11));
    iq_bus.flush_i       = 1'b1;
    iq_bus.stall_i       = 4'b0001;
    iq_bus.issue_num_i   = 2'd2;
    iq_bus.fetch_num_i   = 2'd2;
    iq_bus.fetch_pc0_i   = 32'hEEEE_0000;
    iq_bus.fetch_pc1_i   = 32'hEEEE_0004;
    step();
    iq_bus.flush_i     = 1'b0;
    iq_bus.stall_i     = 4'b0000;
    iq_bus.issue_num_i = 2'd0;
    iq_bus.fetch_num_i = 2'd0;
    chk("flush_valid", 64'(iq_bus.issue_valid_o), 64'(2'b00));
    chk("flush_full", 64'(iq_bus.full_o), 64'(1'b0));
    push(1, 32'h8000_0180, 32'h0);
    chk("post_flush_valid", 64'(iq_bus.issue_valid_o), 64'(2'b01));
    chk("post_flush_pc0", 64'(iq_bus.issue_pc0_o), 64'h0000_0000_8000_0180);
`ifdef INST_QUEUE_STATS_EN
    chk("stat_flushes", 64'(stat_flushes), 64'(2));
`endif

    // ---- simultaneous enqueue/dequeue at count=1 ----
    iq_bus.issue_num_i = 2'd1;
    push(2, 32'h5000, 32'h5004);
    iq_bus.issue_num_i = 2'd0;
    chk("simul_valid", 64'(iq_bus.issue_valid_o), 64'(2'b11));
    chk("simul_pc0", 64'(iq_bus.issue_pc0_o), 64'h5000);
    chk("simul_pc1", 64'(iq_bus.issue_pc1_o), 64'h5004);
    pop(2);
    chk("simul_empty", 64'(iq_bus.issue_valid_o), 64'(2'b00));

    // ---- final reset clears statistics ----
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("final_rst_valid", 64'(iq_bus.issue_valid_o), 64'(2'b00));
`ifdef INST_QUEUE_STATS_EN
    chk("final_stat_full", 64'(stat_full_cycles), 64'(0));
    chk("final_stat_flush", 64'(stat_flushes), 64'(0));
    chk("final_stat_drop", 64'(stat_dropped), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Instruction buffer between fetch (IF) and decode (ID); the consumer of the pipeline controller's stall/flush outputs on the front-end side.
- Accepts up to 2 fetched {pc, inst} pairs per cycle and presents up to 2 oldest entries to decode.
- Holds entries while decode is stalled, and empties completely on flush (exception, ERET, failed branch prediction).
- Raises back-pressure to fetch when it cannot take a full 2-entry packet.

Parameters:
- DEPTH, 16: number of entries. Must be a power of two, ≥4.
- PTR_W, 4: log2(DEPTH).
- ADDR_W, 32: PC width.
- DATA_W, 32: instruction width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- flush_i  in  1  flush from the pipeline controller (flush_to_ibuffer); 1 = discard all contents.
- stall_i  in  4  controller stall vector; only bit 0 (hold decode) is used here.
- fetch_num_i  in  2  number of valid fetch slots this cycle: 0, 1 or 2 (3 is illegal).
- fetch_pc0_i / fetch_pc1_i  in  ADDR_W  PCs of fetch slots 0 and 1; slot 0 is older.
- fetch_inst0_i / fetch_inst1_i  in  DATA_W  instructions of fetch slots 0 and 1.
- full_o  in→out  out  1  1 when free entries < 2; fetch must present fetch_num_i=0 while high.
- issue_valid_o  out  2  bit0 = head entry valid; bit1 = head+1 valid.
- issue_pc0_o / issue_pc1_o  out  ADDR_W  PCs of head and head+1.
- issue_inst0_o / issue_inst1_o  out  DATA_W  instructions of head and head+1.
- issue_num_i  in  2  entries consumed by decode this cycle: 0–2, with issue_num_i ≤ popcount(issue_valid_o).

Behaviour:
- State: head_ptr, tail_ptr (PTR_W each, wrap modulo DEPTH), count (PTR_W+1 bits, 0..DEPTH), entry array.
- Reset (rst=1): head=tail=count=0 next edge. All outputs then read 0: full_o=0, issue_valid_o=00, pc/inst outputs 0. Array contents need no reset.
- Flush (flush_i=1, rst=0): identical to reset. Enqueue and dequeue in that cycle are ignored. Flush has priority over stall.
- Outputs are combinational from registered state:
  - issue_valid_o[0] = (count≥1); issue_valid_o[1] = (count≥2).
  - pc/inst outputs are 0 when the corresponding valid bit is 0.
  - full_o = (DEPTH − count < 2).
- Enqueue amount enq = fetch_num_i when full_o=0, otherwise 0.
  - Fetch data presented while full_o=1 is dropped, and the stats counter (if enabled) records it.
  - Write order: slot0 → tail, slot1 → tail+1 (wraps).
  - fetch_num_i=1 writes slot0 only.
  - fetch_num_i=3 is treated as 2.
- Dequeue amount deq:
  - deq = 0 if stall_i[0]=1.
  - Otherwise deq = min(issue_num_i, count).
- Update per edge: head += deq; tail += enq; count += enq − deq. Simultaneous enqueue and dequeue are legal in every combination, including enqueue into an empty queue: the data appears at the outputs the next cycle, with no bypass.
- Latency: fetch→issue_valid is 1 cycle minimum.
- Wrap-around: pointers wrap silently. A 2-entry write or read straddling DEPTH−1→0 must be correct.
- stall_i[3:1] are ignored. The fetch side is held by the controller directly through full_o and the PC logic.

Optional Feature:
- Macro INST_QUEUE_STATS_EN.
- Defined: adds outputs stat_full_cycles_o (32), stat_flushes_o (32), stat_dropped_o (32).
  - stat_full_cycles_o increments every cycle full_o=1.
  - stat_flushes_o increments on every flush_i=1 cycle.
  - stat_dropped_o increments by fetch_num_i on every cycle with full_o=1 and fetch_num_i≠0.
  - All three clear on rst only, not on flush, and saturate at all-ones.
- Not defined: no ports, no logic; the dropped-fetch case is silent.

Decomposition:
- Shared package: IQ_DEPTH, IQ_PTR_W, the iq_entry_t {pc, inst} typedef, and the fetch/issue width constants, alongside the existing Flush/Stop/RstEnable constants.
- One sub-module, iq_regfile: DEPTH×(ADDR_W+DATA_W) storage with 2 write ports and 2 combinational read ports, indices supplied by inst_queue.

Test Plan:
- Reset/empty: rst=1 for 2 cycles, then fetch_num=2 with pc 0xBFC00000/0xBFC00004. Required: valid=00 during reset; valid=11 with those PCs one cycle later.
- Stall hold: 3 entries queued, stall_i=0001, issue_num=2 for 4 cycles. Required: count stays 3 and outputs unchanged. After releasing stall, 2 entries are consumed in one cycle and valid=01.
- Full back-pressure: push 2/cycle, no dequeue. Required: full_o=1 at count=15 and 16. A push of 2 while full is dropped, count stays 16, and stat_dropped increments by 2 with INST_QUEUE_STATS_EN.
- Wrap-around: fill to 14, drain 13, push 6 entries across index 15→0. Required: issue order and PCs match push order exactly.
- Flush priority: 5 entries queued, same cycle flush_i=1, stall_i=0001, fetch_num=2. Required: next cycle count=0, valid=00; the next push of pc 0x80000180 is issued first.
- Simultaneous enqueue/dequeue: count=1, fetch_num=2, issue_num=1. Required: count=2 next cycle, head = first pushed PC.
